// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit
//   Instruction-fetch stage with a prefetch queue. Sequential fetch requests go out over a
//   valid/ready channel to instruction memory. Returned words are queued with their PC and
//   handed to decode as {pc, pc+4, instr}. Redirects flush the queue and drop wrong-path
//   responses that are still in flight.
// Ports
//   clk, rst          clock (rising edge), synchronous active-high reset
//   pc_s_in           00 sequential, 01 pc_dec_in, 10 pc_alu_in, 11 TRAP_VEC
//   pc_dec_in         decode-stage branch/jump target
//   pc_alu_in         ALU-computed target
//   imem_req_*        fetch request channel; imem_addr is word aligned
//   imem_rsp_*        in-order response words, at least one cycle after accept
//   out_valid/ready   decode handshake for the queue head
//   pc_out, pc_plus4  head PC and head PC + 4
//   instr_out         head instruction word
//   ifq_count         queue occupancy
module fetch_prefetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(32'h100)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             pc_s_in,
    input  logic [XLEN-1:0]        pc_dec_in,
    input  logic [XLEN-1:0]        pc_alu_in,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [XLEN-1:0]        imem_addr,
    input  logic                   imem_rsp_valid,
    input  logic [31:0]            imem_rsp_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        pc_out,
    output logic [XLEN-1:0]        pc_plus4,
    output logic [31:0]            instr_out,
    output logic [$clog2(DEPTH):0] ifq_count
);

    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned CW     = AW + 1;
    localparam logic [CW:0] CREDIT = (CW+1)'(DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [AW-1:0]   head_q, head_d;
    logic [AW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   discard_q, discard_d;

    logic [XLEN-1:0] q_pc    [DEPTH];
    logic [31:0]     q_instr [DEPTH];

    logic            redirect;
    logic [XLEN-1:0] target_raw;
    logic [XLEN-1:0] target;
    logic [CW:0]     used;
    logic            accept;
    logic            pop;
    logic            drop;
    logic            push;

    always_comb begin
        redirect = !rst && (pc_s_in != 2'b00);
        case (pc_s_in)
            2'b01:   target_raw = pc_dec_in;
            2'b10:   target_raw = pc_alu_in;
            2'b11:   target_raw = TRAP_VEC;
            default: target_raw = fetch_pc_q;
        endcase
        target = target_raw & ~XLEN'(3);
    end

    // Queued words plus in-flight requests never exceed DEPTH, so a response always has a slot.
    assign used           = {1'b0, count_q} + {1'b0, outst_q};
    assign imem_req_valid = !rst && (pc_s_in == 2'b00) && (used < CREDIT);
    assign imem_addr      = fetch_pc_q;
    assign accept         = imem_req_valid && imem_req_ready;

    assign out_valid = !rst && (pc_s_in == 2'b00) && (count_q != '0);
    assign pop       = out_valid && out_ready;

    // Wrong-path words are dropped while discard is pending, and also on the redirect cycle.
    assign drop = imem_rsp_valid && (discard_q != '0);
    assign push = imem_rsp_valid && !drop && !redirect;

    always_comb begin
        outst_d = outst_q + CW'(accept) - CW'(imem_rsp_valid);
        if (redirect) begin
            fetch_pc_d = target;
            rsp_pc_d   = target;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            discard_d  = outst_d;
        end else begin
            fetch_pc_d = accept ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
            rsp_pc_d   = push ? rsp_pc_q + XLEN'(4) : rsp_pc_q;
            head_d     = head_q + AW'(pop);
            tail_d     = tail_q + AW'(push);
            count_d    = count_q + CW'(push) - CW'(pop);
            discard_d  = drop ? discard_q - CW'(1) : discard_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            outst_q    <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
        end
    end

    // Storage needs no reset; occupancy decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[tail_q]    <= rsp_pc_q;
            q_instr[tail_q] <= imem_rsp_data;
        end
    end

    // An empty queue shows the PC the next word will carry.
    always_comb begin
        if (rst) begin
            pc_out    = RESET_PC;
            instr_out = '0;
        end else if (count_q == '0) begin
            pc_out    = rsp_pc_q;
            instr_out = '0;
        end else begin
            pc_out    = q_pc[head_q];
            instr_out = q_instr[head_q];
        end
    end

    assign pc_plus4  = pc_out + XLEN'(4);
    assign ifq_count = count_q;

endmodule
